// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - pushbutton/switch inputs and ALU-facing outputs of the op sequencer
interface alu_op_sequencer_if #(
    parameter int N = 4
);
    logic         btn;
    logic         hold;
    logic [N-1:0] sw_a;
    logic [N-1:0] sw_b;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic [2:0]   mode;
    logic [7:0]   mode_oh;
    logic         click;
    logic         upd;

    modport master (
        output btn, hold, sw_a, sw_b,
        input  in1, in2, mode, mode_oh, click, upd
    );

    modport slave (
        input  btn, hold, sw_a, sw_b,
        output in1, in2, mode, mode_oh, click, upd
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - debounced op button, mode counter and registered operands feeding the ALU
module alu_op_sequencer #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus
);
    localparam int            CW       = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic {RELEASED, PRESSED} press_t;

    press_t        state, state_nx;
    logic          btn_m, btn_s, btn_db;
    logic [CW-1:0] cnt;
    logic [N-1:0]  a_m, a_s, b_m, b_s;
    logic [N-1:0]  in1_q, in2_q, in1_nx, in2_nx;
    logic [2:0]    mode_q, mode_nx;
    logic [7:0]    mode_oh_q;
    logic          click_q, click_nx;
    logic          chg_q, upd_q;

    // Two-flop synchronisers, then a level is accepted only after DB_CYCLES unbroken cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            a_m    <= '0;
            a_s    <= '0;
            b_m    <= '0;
            b_s    <= '0;
            btn_db <= 1'b0;
            cnt    <= '0;
        end else begin
            btn_m <= bus.btn;
            btn_s <= btn_m;
            a_m   <= bus.sw_a;
            a_s   <= a_m;
            b_m   <= bus.sw_b;
            b_s   <= b_m;
            if (btn_s == btn_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                btn_db <= btn_s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        click_nx = 1'b0;
        case (state)
            RELEASED: if (btn_db) begin
                state_nx = PRESSED;
                click_nx = 1'b1;
            end
            PRESSED: if (!btn_db) begin
                state_nx = RELEASED;
            end
        endcase

        mode_nx = mode_q;
        if (click_nx && !bus.hold) begin
            mode_nx = mode_q + 3'd1;
        end
        in1_nx = bus.hold ? in1_q : a_s;
        in2_nx = bus.hold ? in2_q : b_s;
    end

    // chg_q marks the edge where an ALU input moved; upd follows one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RELEASED;
            click_q   <= 1'b0;
            mode_q    <= 3'd0;
            mode_oh_q <= 8'h01;
            in1_q     <= '0;
            in2_q     <= '0;
            chg_q     <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            click_q   <= click_nx;
            mode_q    <= mode_nx;
            mode_oh_q <= 8'b1 << mode_nx;
            in1_q     <= in1_nx;
            in2_q     <= in2_nx;
            chg_q     <= (mode_nx != mode_q) || (in1_nx != in1_q) || (in2_nx != in2_q);
            upd_q     <= chg_q;
        end
    end

    assign bus.in1     = in1_q;
    assign bus.in2     = in2_q;
    assign bus.mode    = mode_q;
    assign bus.mode_oh = mode_oh_q;
    assign bus.click   = click_q;
    assign bus.upd     = upd_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed bench with a cycle-level reference model of the op sequencer
module tb_alu_op_sequencer;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.N(4)) bus ();

    alu_op_sequencer #(.N(4), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: a raw level is believed once the synchronised button has
    // disagreed with the accepted level for DB straight cycles.
    int          cyc = 0;
    logic        started = 1'b0;
    logic        m_rst_q = 1'b0, m_rst_q2 = 1'b0;
    logic        m_s1 = 1'b0;
    logic [DB-1:0] m_bs = '0;
    logic        m_db = 1'b0, m_db_d = 1'b0;
    logic        m_click = 1'b0;
    logic [2:0]  m_mode = 3'd0;
    logic [3:0]  m_a1 = '0, m_a2 = '0, m_b1 = '0, m_b2 = '0, m_in1 = '0, m_in2 = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m_rst_q  <= !rst_n;
        m_rst_q2 <= m_rst_q;
        if (!rst_n) begin
            started <= 1'b1;
            m_s1    <= 1'b0;
            m_bs    <= '0;
            m_db    <= 1'b0;
            m_db_d  <= 1'b0;
            m_click <= 1'b0;
            m_mode  <= 3'd0;
            m_a1 <= '0; m_a2 <= '0; m_b1 <= '0; m_b2 <= '0;
            m_in1 <= '0; m_in2 <= '0;
        end else begin
            m_s1 <= bus.btn;
            m_bs <= {m_bs[DB-2:0], m_s1};
            if (m_bs == {DB{~m_db}}) m_db <= ~m_db;
            m_db_d  <= m_db;
            m_click <= m_db & ~m_db_d;
            if (m_db && !m_db_d && !bus.hold) m_mode <= m_mode + 3'd1;
            m_a1 <= bus.sw_a; m_a2 <= m_a1;
            m_b1 <= bus.sw_b; m_b2 <= m_b1;
            if (!bus.hold) begin
                m_in1 <= m_a2;
                m_in2 <= m_b2;
            end
        end
    end

    int n_cmp = 0, n_err = 0;
    int n_clicks = 0, n_upd = 0, last_click_cyc = -1;
    int req_seq = 0, ack_seq = 0;
    int e_clicks, e_ccyc, e_mode, e_oh, e_in1, e_in2, e_upds;
    logic [10:0] snap1 = '0, snap2 = '0;
    logic        exp_upd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            exp_upd = (m_rst_q || m_rst_q2) ? 1'b0 : (snap1 != snap2);
            check("in1",     32'(bus.in1),     32'(m_in1));
            check("in2",     32'(bus.in2),     32'(m_in2));
            check("mode",    32'(bus.mode),    32'(m_mode));
            check("mode_oh", 32'(bus.mode_oh), 32'(8'b1 << m_mode));
            check("click",   32'(bus.click),   32'(m_click));
            check("upd",     32'(bus.upd),     32'(exp_upd));
            if (bus.click === 1'b1) begin
                n_clicks++;
                last_click_cyc = cyc;
            end
            if (bus.upd === 1'b1) n_upd++;
            if (req_seq != ack_seq) begin
                ack_seq = req_seq;
                if (e_clicks >= 0) check("click_count", 32'(n_clicks), 32'(e_clicks));
                if (e_ccyc >= 0)   check("click_cycle", 32'(last_click_cyc), 32'(e_ccyc));
                if (e_mode >= 0)   check("lit_mode", 32'(bus.mode), 32'(e_mode));
                if (e_oh >= 0)     check("lit_mode_oh", 32'(bus.mode_oh), 32'(e_oh));
                if (e_in1 >= 0)    check("lit_in1", 32'(bus.in1), 32'(e_in1));
                if (e_in2 >= 0)    check("lit_in2", 32'(bus.in2), 32'(e_in2));
                if (e_upds >= 0)   check("upd_count", 32'(n_upd), 32'(e_upds));
            end
        end
        snap2 = snap1;
        snap1 = {m_mode, m_in1, m_in2};
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lit(input int clicks, input int ccyc, input int mode, input int oh,
                       input int in1, input int in2, input int upds);
        e_clicks = clicks; e_ccyc = ccyc; e_mode = mode; e_oh = oh;
        e_in1 = in1; e_in2 = in2; e_upds = upds;
        req_seq++;
    endtask

    logic [7:0] oh_tab [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    int c, r;

    initial begin
        rst_n = 1'b0;
        bus.btn = 1'b0; bus.hold = 1'b0; bus.sw_a = 4'h0; bus.sw_b = 4'h0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        lit(0, -1, 0, 8'h01, 0, 0, 0);

        // single long press: click DB+2 edges after the first sampling edge
        c = cyc;
        bus.btn = 1'b1;
        tick(30);
        lit(1, c + 1 + DB + 2, 1, 8'h02, 0, 0, 1);
        bus.btn = 1'b0;
        tick(12);

        // glitch one cycle shorter than the debounce window
        bus.btn = 1'b1;
        tick(DB - 1);
        bus.btn = 1'b0;
        tick(15);
        lit(1, -1, 1, 8'h02, -1, -1, 1);

        // eight clean presses from mode 0 walk all codes and wrap
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            bus.btn = 1'b1;
            tick(10);
            lit(2 + i, -1, (i + 1) % 8, oh_tab[i], -1, -1, 2 + i);
            bus.btn = 1'b0;
            tick(10);
        end

        // operands: three edges of latency, one update strobe for both
        bus.sw_a = 4'hA; bus.sw_b = 4'h5;
        tick(3);
        lit(9, -1, 0, 8'h01, 4'hA, 4'h5, -1);
        tick(3);
        lit(-1, -1, -1, -1, 4'hA, 4'h5, 10);

        // hold freezes operands and mode but not the click
        bus.hold = 1'b1; bus.sw_a = 4'h3; bus.btn = 1'b1;
        tick(10);
        lit(10, -1, 0, 8'h01, 4'hA, 4'h5, 10);
        bus.btn = 1'b0;
        tick(10);
        bus.hold = 1'b0;
        tick(4);
        lit(10, -1, 0, 8'h01, 4'h3, 4'h5, 11);

        // reset lands while the debounce count is at 2
        bus.btn = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        r = cyc;
        rst_n = 1'b1;
        lit(10, -1, 0, 8'h01, 0, 0, -1);
        tick(9);
        lit(11, r + 7, 1, 8'h02, 4'h3, 4'h5, -1);
        bus.btn = 1'b0;
        tick(12);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
